// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and helpers for the data-memory bus adapter.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (see dmem_bus_adapter).
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Adapter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmemState_t;

  // Load/store funct3 encodings
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Captured bus request payload
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } busReq_t;

  // True when the access size does not fit its natural alignment
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      LS_H, LS_HU: mis = addrLo[0];
      LS_W:        mis = |addrLo;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Places store data onto the byte lanes it will be written to.
// Bytes are replicated to every lane, halfwords are shifted to their half.
module dmem_store_align
  import dmem_pkg::*;
(
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [1:0]        addrLo,
  input  logic [2:0]        funct3M,
  output logic [DATA_W-1:0] wdataShifted_c
);

  // Lane placement by access size
  always_comb begin
    wdataShifted_c = WriteDataM;
    case (funct3M)
      LS_B:    wdataShifted_c = {4{WriteDataM[7:0]}};
      LS_H:    wdataShifted_c = DATA_W'({16'h0000, WriteDataM[15:0]}) << {addrLo, 3'b000};
      default: wdataShifted_c = WriteDataM;
    endcase
  end

endmodule

// File: rtl/dmem_bus_adapter.sv
// MEM-stage to valid/ready data-memory bus adapter. One bus transaction per
// load/store, pipeline stalled until the response (or timeout) arrives.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN traps misaligned accesses
// instead of issuing them to the truncated word address.
module dmem_bus_adapter
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [STRB_W-1:0] byteEnable,
  input  logic [2:0]        funct3M,
  output logic              StallMem,
  output logic [DATA_W-1:0] RD_data,
  output logic              access_fault,
  output logic              misalign_fault,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [DATA_W-1:0] bus_req_addr,
  output logic              bus_req_we,
  output logic [DATA_W-1:0] bus_req_wdata,
  output logic [STRB_W-1:0] bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  dmemState_t        state;
  dmemState_t        nextState;
  busReq_t           reqQ;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdDataQ;
  logic              accessFaultQ;
  logic [DATA_W-1:0] wdataAligned_c;
  logic              memReq_c;
  logic              trapReq_c;
  logic              timeoutHit_c;
  logic              captureEn;
  logic              loadRsp;
  logic              faultNext;

  assign memReq_c     = MemReadM | MemWriteM;
  assign timeoutHit_c = TO_EN && (cnt == CNT_W'(CNT_LAST));

  dmem_store_align uAlign (
    .WriteDataM     (WriteDataM),
    .addrLo         (ALUResultM[1:0]),
    .funct3M        (funct3M),
    .wdataShifted_c (wdataAligned_c)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalignFaultQ;

  assign trapReq_c = isMisaligned(funct3M, ALUResultM[1:0]);

  // Misalign pulse lands in DONE, one cycle after the trapped IDLE cycle
  always_ff @(posedge clk) begin
    if (clr) misalignFaultQ <= 1'b0;
    else     misalignFaultQ <= (state == IDLE) && memReq_c && trapReq_c;
  end

  assign misalign_fault = misalignFaultQ;
`else
  assign trapReq_c      = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= nextState;
  end

  // Next state, stall and datapath enables. In REQ a timeout beats a late
  // ready; in WAIT a response beats a coincident timeout.
  always_comb begin
    nextState = state;
    StallMem  = 1'b0;
    captureEn = 1'b0;
    loadRsp   = 1'b0;
    faultNext = 1'b0;
    case (state)
      IDLE: begin
        if (memReq_c) begin
          StallMem = 1'b1;
          if (trapReq_c) begin
            nextState = DONE;
          end else begin
            captureEn = 1'b1;
            nextState = REQ;
          end
        end
      end
      REQ: begin
        StallMem = 1'b1;
        if (timeoutHit_c) begin
          faultNext = 1'b1;
          nextState = DONE;
        end else if (bus_req_ready) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        StallMem = 1'b1;
        if (bus_rsp_valid) begin
          loadRsp   = ~reqQ.we;
          faultNext = bus_rsp_err;
          nextState = DONE;
        end else if (timeoutHit_c) begin
          faultNext = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Timeout counter: cleared on entry to REQ, counts REQ and WAIT cycles
  always_ff @(posedge clk) begin
    if (clr)                                cnt <= '0;
    else if (captureEn)                     cnt <= '0;
    else if (state == REQ || state == WAIT) cnt <= cnt + CNT_W'(1);
  end

  // Request capture, read data hold and fault pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      reqQ         <= '0;
      rdDataQ      <= '0;
      accessFaultQ <= 1'b0;
    end else begin
      accessFaultQ <= faultNext;
      if (captureEn) begin
        reqQ <= '{addr:  {ALUResultM[DATA_W-1:2], 2'b00},
                  we:    MemWriteM,
                  wdata: wdataAligned_c,
                  wstrb: MemWriteM ? byteEnable : STRB_W'(0)};
      end
      if (loadRsp) rdDataQ <= bus_rsp_rdata;
    end
  end

  assign bus_req_valid = (state == REQ);
  assign bus_req_addr  = reqQ.addr;
  assign bus_req_we    = reqQ.we;
  assign bus_req_wdata = reqQ.wdata;
  assign bus_req_wstrb = reqQ.wstrb;
  assign RD_data       = rdDataQ;
  assign access_fault  = accessFaultQ;

endmodule
